// File: rtl/mask_scan_pkg.sv
// Shared definitions for the mask scanner slice.
//   WIDTH_DEF / IDXW_DEF : default mask width and index width
//   state_t              : scanner FSM encoding (IDLE=0, SCAN=1)
package mask_scan_pkg;
    localparam int WIDTH_DEF = 32;
    localparam int IDXW_DEF  = 5;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;
endpackage

// File: rtl/lowest_set_bit.sv
// Combinational priority encoder with one-hot detection.
// Ports:
//   Vec   in  WIDTH  vector to examine
//   Index out IDXW   position of the lowest set bit (0 when Vec is zero)
//   Any   out 1      Vec has at least one bit set
//   One   out 1      Vec has exactly one bit set
module lowest_set_bit
    import mask_scan_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int IDXW  = IDXW_DEF
) (
    input  logic [WIDTH-1:0] Vec,
    output logic [IDXW-1:0]  Index,
    output logic             Any,
    output logic             One
);
    logic [WIDTH-1:0] w_clear_low;

    // Walk from MSB down so the lowest set bit is the last one to win.
    always_comb begin
        Index = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (Vec[i]) begin
                Index = IDXW'(i);
            end
        end
    end

    // Clearing the lowest set bit leaves zero exactly when Vec was one-hot.
    assign w_clear_low = Vec & (Vec - WIDTH'(1));
    assign Any         = |Vec;
    assign One         = Any && (w_clear_low == '0);
endmodule

// File: rtl/mask_scanner.sv
// Walks a bit mask and emits the index of every set bit, LSB first, one
// index per downstream handshake. An all-zero mask yields a single beat
// flagged None.
// Ports:
//   clk       in   1      clock
//   reset     in   1      synchronous reset, active-high
//   InValid   in   1      Mask is valid
//   InReady   out  1      scanner is idle and can accept a mask
//   Mask      in   WIDTH  mask to scan, sampled on InValid && InReady
//   OutValid  out  1      Index/Last/None are valid
//   OutReady  in   1      downstream accepts the current beat
//   Index     out  IDXW   lowest remaining set bit
//   Last      out  1      final beat for this mask
//   None      out  1      mask was all-zero (single beat, Index=0)
module mask_scanner
    import mask_scan_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int IDXW  = IDXW_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] Mask,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [IDXW-1:0]  Index,
    output logic             Last,
    output logic             None
);
    state_t           r_state;
    logic [WIDTH-1:0] r_remaining;
    logic             r_zero;

    state_t           w_state_nxt;
    logic [WIDTH-1:0] w_remaining_nxt;
    logic             w_zero_nxt;
    logic [IDXW-1:0]  w_idx;
    logic             w_any;
    logic             w_one;
    logic             w_last;

    lowest_set_bit #(
        .WIDTH (WIDTH),
        .IDXW  (IDXW)
    ) u_lsb (
        .Vec   (r_remaining),
        .Index (w_idx),
        .Any   (w_any),
        .One   (w_one)
    );

    // Outputs depend on registers only; no input reaches them combinationally.
    assign w_last   = r_zero | w_one;
    assign InReady  = (r_state == IDLE);
    assign OutValid = (r_state == SCAN);
    assign Index    = w_idx;
    assign Last     = OutValid & w_last;
    assign None     = OutValid & r_zero;

    always_comb begin
        w_state_nxt     = r_state;
        w_remaining_nxt = r_remaining;
        w_zero_nxt      = r_zero;
        case (r_state)
            IDLE: begin
                if (InValid) begin
                    w_remaining_nxt = Mask;
                    w_zero_nxt      = (Mask == '0);
                    w_state_nxt     = SCAN;
                end
            end
            SCAN: begin
                if (OutReady) begin
                    // Drop the bit just emitted; a zero vector stays zero.
                    w_remaining_nxt = r_remaining & (r_remaining - WIDTH'(1));
                    if (w_last) begin
                        w_state_nxt = IDLE;
                        w_zero_nxt  = 1'b0;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_remaining <= '0;
            r_zero      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_remaining <= w_remaining_nxt;
            r_zero      <= w_zero_nxt;
        end
    end

    // w_any is informational; the FSM relies on the one-hot flag.
    logic w_unused;
    assign w_unused = w_any;
endmodule

// File: tb/tb_mask_scanner.sv
module tb_mask_scanner;
    localparam int WIDTH = 32;
    localparam int IDXW  = 5;

    logic             clk = 1'b0;
    logic             reset;
    logic             InValid;
    logic             InReady;
    logic [WIDTH-1:0] Mask;
    logic             OutValid;
    logic             OutReady;
    logic [IDXW-1:0]  Index;
    logic             Last;
    logic             None;

    int errors = 0;
    int checks = 0;

    mask_scanner #(.WIDTH(WIDTH), .IDXW(IDXW)) dut (
        .clk      (clk),
        .reset    (reset),
        .InValid  (InValid),
        .InReady  (InReady),
        .Mask     (Mask),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .Index    (Index),
        .Last     (Last),
        .None     (None)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: expected beat list is simply the ascending positions of the
    // set bits, or a single index-0 beat for an empty mask.
    task automatic scan_mask(input logic [31:0] m, input int mode,
                             input bit hold, input logic [31:0] other);
        int exp_q[$];
        int k;
        int guard;
        bit rdy;
        for (int i = 0; i < WIDTH; i++) if (m[i]) exp_q.push_back(i);
        if (m == 0) exp_q.push_back(0);

        @(negedge clk);
        guard = 0;
        while (InReady !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("accept_ready", {31'd0, InReady}, 32'd1);
        InValid  = 1'b1;
        Mask     = m;
        OutReady = 1'b0;
        @(posedge clk); #1;
        if (hold) Mask = other;
        else begin
            InValid = 1'b0;
            Mask    = $urandom;
        end

        k = 0;
        guard = 0;
        while (k < exp_q.size() && guard < 200) begin
            @(negedge clk);
            chk("beat_valid",   {31'd0, OutValid}, 32'd1);
            chk("beat_inready", {31'd0, InReady},  32'd0);
            chk("beat_index",   {27'd0, Index},    32'(exp_q[k]));
            chk("beat_last",    {31'd0, Last},     (k == exp_q.size() - 1) ? 32'd1 : 32'd0);
            chk("beat_none",    {31'd0, None},     (m == 0) ? 32'd1 : 32'd0);
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (guard % 2 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            OutReady = rdy;
            @(posedge clk); #1;
            if (rdy) k++;
            guard++;
        end
        if (k < exp_q.size()) chk("beat_timeout", 32'(k), 32'(exp_q.size()));

        @(negedge clk);
        chk("idle_inready",  {31'd0, InReady},  32'd1);
        chk("idle_outvalid", {31'd0, OutValid}, 32'd0);
        InValid  = 1'b0;
        OutReady = 1'b0;
    endtask

    initial begin
        logic [31:0] rm;
        reset    = 1'b1;
        InValid  = 1'b0;
        OutReady = 1'b0;
        Mask     = '0;

        // Reset held two cycles, then released
        @(posedge clk); @(posedge clk); #1;
        chk("rst_inready",  {31'd0, InReady},  32'd1);
        chk("rst_outvalid", {31'd0, OutValid}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("rel_inready",  {31'd0, InReady},  32'd1);
        chk("rel_outvalid", {31'd0, OutValid}, 32'd0);
        chk("rel_index",    {27'd0, Index},    32'd0);
        chk("rel_last",     {31'd0, Last},     32'd0);
        chk("rel_none",     {31'd0, None},     32'd0);

        // Directed patterns
        scan_mask(32'h0000_0092, 0, 1'b0, 32'h0);
        scan_mask(32'h0000_0000, 0, 1'b0, 32'h0);
        scan_mask(32'hFFFF_FFFF, 1, 1'b0, 32'h0);
        scan_mask(32'h8000_0000, 0, 1'b0, 32'h0);
        scan_mask(32'h0000_0300, 0, 1'b1, 32'h0000_00F0);

        // Reset mid-scan
        @(negedge clk);
        InValid = 1'b1;
        Mask    = 32'h8000_0001;
        @(posedge clk); #1;
        InValid = 1'b0;
        @(negedge clk);
        chk("mid_first_index", {27'd0, Index},    32'd0);
        chk("mid_first_valid", {31'd0, OutValid}, 32'd1);
        chk("mid_first_last",  {31'd0, Last},     32'd0);
        OutReady = 1'b1;
        @(posedge clk); #1;
        OutReady = 1'b0;
        reset    = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_inready",  {31'd0, InReady},  32'd1);
        chk("mid_rst_outvalid", {31'd0, OutValid}, 32'd0);
        chk("mid_rst_index",    {27'd0, Index},    32'd0);
        chk("mid_rst_last",     {31'd0, Last},     32'd0);

        // Randomized masks and backpressure
        for (int t = 0; t < 20; t++) begin
            case (t % 4)
                0:       rm = $urandom;
                1:       rm = $urandom & $urandom & $urandom;
                2:       rm = 32'd1 << $urandom_range(0, 31);
                default: rm = $urandom | $urandom;
            endcase
            scan_mask(rm, $urandom_range(0, 2), 1'b0, 32'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
